reg_scoreboard: RTL and testbench
=================================

# reg_scoreboard

Register scoreboard for the 16-bit pipelined core, replacing per-stage destination comparisons with per-register pending-write counters. It records each register-writing instruction as it leaves ID for EX, releases the entry at write-back or squash, and stalls ID while a source register has a write in flight. It drives the same stall controls as the existing hazard unit (`pc_en`, `if_id_en`, ID/EX bubble select), so the two are interchangeable at the ID stage.

## Interface
- `NREG`, 8: architectural registers; r0 is hard-wired zero.
- `AW`, 3: register address width, log2(NREG).
- `CW`, 2: pending counter width; `MAX_PEND` = 2^CW−1 = 3, which equals the EX/MEM/WB in-flight maximum.

- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `rs1`, in, AW: ID-stage source 1.
- `rs1_use`, in, 1: source 1 is read.
- `rs2`, in, AW: ID-stage source 2.
- `rs2_use`, in, 1: source 2 is read.
- `issue_valid`, in, 1: valid instruction in ID requesting to enter EX.
- `issue_wb_en`, in, 1: that instruction writes a register.
- `issue_rd`, in, AW: its destination.
- `wb_valid`, in, 1: instruction retiring from WB with a register write.
- `wb_rd`, in, AW: retiring destination.
- `kill_valid`, in, 1: the EX-stage instruction is squashed and held a reservation.
- `kill_rd`, in, AW: squashed destination.
- `stall`, out, 1: ID must hold.
- `pc_en`, out, 1: equals ~stall.
- `if_id_en`, out, 1: equals ~stall.
- `id_ex_bubble`, out, 1: equals stall; selects NOP into ID/EX.
- `busy`, out, 1: any counter nonzero.
- `err`, out, 1: sticky overflow/underflow flag.

## Operation
- State: `cnt[1..NREG-1]`, each CW bits, plus the `err` flag. r0 has no counter; its pending value is always 0.
- Hazard for source X: `rsX_use && rsX != 0 && cnt[rsX] != 0`.
  - `stall` = hazard(rs1) OR hazard(rs2).
  - `stall` is purely combinational from the registered counters and the current rs inputs.
- Effective issue: `inc = issue_valid && issue_wb_en && !stall && issue_rd != 0`. The stall gating is internal, so the pipeline needs no extra gating.
- Decrements:
  - `dec_wb = wb_valid && wb_rd != 0`.
  - `dec_kill = kill_valid && kill_rd != 0`.
- Per-register next value = cnt + inc_hit − dec_wb_hit − dec_kill_hit. The delta is in the range −2..+1.
  - Issue and retire to the same rd in the same cycle: net 0.
  - Retire and kill to the same rd in the same cycle: −2.
- Boundary rules:
  - Result > MAX_PEND: counter holds MAX_PEND and `err` sets.
  - Result < 0: counter clamps to 0 and `err` sets.
  - `err` clears only on reset.
- A write retiring in cycle N still stalls a dependent instruction in cycle N. This preserves the existing hazard unit's rule that a WB-stage match stalls. The dependent instruction issues in N+1.
- `busy` = OR of all counters.

## Timing
- Reset (asynchronous, `rst_n` low): all counters 0 and `err` 0. Consequently `stall`=0, `pc_en`=1, `if_id_en`=1, `id_ex_bubble`=0, `busy`=0 from reset assertion onward.
- Reset mid-operation discards all reservations immediately. The pipeline is reset by the same signal.
- Stall latency: 0 cycles, combinational from the rs inputs.
- Reservation latency: an issue in cycle N is visible to the ID instruction in cycle N+1. The back-to-back dependent pair therefore stalls in N+1.
- Release latency: a retire or kill in cycle N takes effect in cycle N+1.
- Typical RAW distance for a 5-stage pipeline: 3 stall cycles (EX, MEM and WB occupancy).

## Structure
- Shared package `core_pkg`, holding:
  - `REG_AW` and `NREG`;
  - `MAX_PEND`;
  - the `reg_id_t` typedef;
  - the `R0` constant.
- Sub-module `sb_cell`: one CW-bit saturating up/down counter, with `inc`, `dec_a` and `dec_b` inputs and `nz` and `err` outputs. It is instantiated NREG−1 times in a generate loop. The top level handles decode, the stall OR-tree and the `err` OR-reduction.

## Test plan
- Reset check: with `rst_n` low, then release → `stall`=0, `pc_en`=1, `busy`=0 and `err`=0, with no clock edge required.
- Back-to-back RAW hazard:
  - Stimulus: issue rd=3, then ID presents rs1=3 (`rs1_use`=1).
  - Required: `stall`=1 for 3 cycles.
  - Required: `wb_valid` with `wb_rd`=3 in the third stall cycle → `stall`=0 in the next cycle.
- Register zero: issue rd=0, then rs1=0 → `stall` never asserts and `busy` stays 0.
- Simultaneous events on r5:
  - Stimulus: cnt[5]=1, then issue rd=5 together with retire `wb_rd`=5 in the same cycle.
  - Required: cnt[5] remains 1.
  - Stimulus: kill rd=5 together with retire rd=5 at cnt=2.
  - Required: cnt[5] becomes 0 and `err` stays 0.
- Issue blocked by stall:
  - Stimulus: `issue_valid` with rd=4 while `stall`=1 from rs2=2.
  - Required: cnt[4] stays unchanged.
- Error detection:
  - Stimulus: retire rd=6 with cnt[6]=0.
  - Required: `err`=1 and cnt[6]=0.
  - Stimulus: a 4th issue to rd=6 without any retire.
  - Required: counter holds 3 and `err` stays 1 until reset.

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// core_pkg : constants and types shared by the 16-bit core register logic
// Rev 1.0
// ---------------------------------------------------------------------------
package core_pkg;

  localparam int NREG     = 8;
  localparam int REG_AW   = 3;
  localparam int PEND_CW  = 2;
  localparam int MAX_PEND = (1 << PEND_CW) - 1;

  typedef logic [REG_AW-1:0] reg_id_t;

  localparam reg_id_t R0 = '0;

  // One-hot decode of a register id, gated by an enable and never hitting r0.
  function automatic logic [NREG-1:0] reg_onehot(input logic en, input reg_id_t id);
    logic [NREG-1:0] v;
    v = '0;
    if (en && (id != R0)) begin
      v[id] = 1'b1;
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sb_cell.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sb_cell : saturating pending-write counter for one architectural register
// Rev 1.0
// ---------------------------------------------------------------------------
module sb_cell #(
  parameter int CW = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec_a,
  input  logic dec_b,
  output logic nz,
  output logic err
);

  localparam logic [CW:0] C_MAX = {1'b0, {CW{1'b1}}};

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [CW:0]   w_up;
  logic [1:0]    w_down;
  logic [CW:0]   w_down_ext;
  logic [CW:0]   w_res;

  // Up and down parts are kept unsigned so underflow is a plain compare.
  always_comb begin
    w_up       = {1'b0, cnt_q} + {{CW{1'b0}}, inc};
    w_down     = {1'b0, dec_a} + {1'b0, dec_b};
    w_down_ext = {{(CW-1){1'b0}}, w_down};
    w_res      = '0;
    cnt_d      = cnt_q;
    err_d      = err_q;
    if (w_up < w_down_ext) begin
      cnt_d = '0;
      err_d = 1'b1;
    end else begin
      w_res = w_up - w_down_ext;
      if (w_res > C_MAX) begin
        cnt_d = C_MAX[CW-1:0];
        err_d = 1'b1;
      end else begin
        cnt_d = w_res[CW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign nz  = |cnt_q;
  assign err = err_q;

endmodule
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_scoreboard : per-register pending-write tracking and ID-stage stall
// Rev 1.0
// ---------------------------------------------------------------------------
module reg_scoreboard
  import core_pkg::*;
#(
  parameter int NREG = core_pkg::NREG,
  parameter int AW   = core_pkg::REG_AW,
  parameter int CW   = core_pkg::PEND_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rs1,
  input  logic          rs1_use,
  input  logic [AW-1:0] rs2,
  input  logic          rs2_use,
  input  logic          issue_valid,
  input  logic          issue_wb_en,
  input  logic [AW-1:0] issue_rd,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_rd,
  input  logic          kill_valid,
  input  logic [AW-1:0] kill_rd,
  output logic          stall,
  output logic          pc_en,
  output logic          if_id_en,
  output logic          id_ex_bubble,
  output logic          busy,
  output logic          err
);

  logic [NREG-1:0] w_inc_hit;
  logic [NREG-1:0] w_wb_hit;
  logic [NREG-1:0] w_kill_hit;
  logic [NREG-1:0] w_nz;
  logic [NREG-1:0] w_err;
  logic            w_haz1;
  logic            w_haz2;

  // Issue is gated by the stall here so a held instruction never reserves.
  always_comb begin
    w_haz1     = rs1_use && (rs1 != R0) && w_nz[rs1];
    w_haz2     = rs2_use && (rs2 != R0) && w_nz[rs2];
    stall      = w_haz1 || w_haz2;
    w_inc_hit  = reg_onehot(issue_valid && issue_wb_en && !stall, issue_rd);
    w_wb_hit   = reg_onehot(wb_valid, wb_rd);
    w_kill_hit = reg_onehot(kill_valid, kill_rd);
  end

  assign w_nz[0]  = 1'b0;
  assign w_err[0] = 1'b0;

  generate
    for (genvar i = 1; i < NREG; i++) begin : g_cell
      sb_cell #(
        .CW (CW)
      ) u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_inc_hit[i]),
        .dec_a (w_wb_hit[i]),
        .dec_b (w_kill_hit[i]),
        .nz    (w_nz[i]),
        .err   (w_err[i])
      );
    end
  endgenerate

  assign pc_en        = ~stall;
  assign if_id_en     = ~stall;
  assign id_ex_bubble = stall;
  assign busy         = |w_nz;
  assign err          = |w_err;

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_reg_scoreboard : directed checks of the register scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] rs1 = '0, rs2 = '0, issue_rd = '0, wb_rd = '0, kill_rd = '0;
  logic       rs1_use = 0, rs2_use = 0, issue_valid = 0, issue_wb_en = 0;
  logic       wb_valid = 0, kill_valid = 0;
  logic       stall, pc_en, if_id_en, id_ex_bubble, busy, err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rs1          (rs1),
    .rs1_use      (rs1_use),
    .rs2          (rs2),
    .rs2_use      (rs2_use),
    .issue_valid  (issue_valid),
    .issue_wb_en  (issue_wb_en),
    .issue_rd     (issue_rd),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .kill_valid   (kill_valid),
    .kill_rd      (kill_rd),
    .stall        (stall),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .id_ex_bubble (id_ex_bubble),
    .busy         (busy),
    .err          (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    issue_valid = 0; issue_wb_en = 0; wb_valid = 0; kill_valid = 0;
    rs1_use = 0; rs2_use = 0;
  endtask

  task automatic iss(input logic [2:0] rd);
    issue_valid = 1; issue_wb_en = 1; issue_rd = rd;
    tick();
    issue_valid = 0; issue_wb_en = 0;
  endtask

  task automatic ret(input logic [2:0] rd);
    wb_valid = 1; wb_rd = rd;
    tick();
    wb_valid = 0;
  endtask

  task automatic probe1(input logic [2:0] r);
    rs1 = r; rs1_use = 1; #2;
  endtask

  initial begin
    // Reset values before any clock edge
    #3;
    chk("rst_stall", stall, 0);
    chk("rst_pc_en", pc_en, 1);
    chk("rst_if_id_en", if_id_en, 1);
    chk("rst_bubble", id_ex_bubble, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst_n = 1;
    tick();

    // Back-to-back RAW on r3
    iss(3'd3);
    probe1(3'd3);
    chk("raw_stall_c1", stall, 1);
    chk("raw_pc_en_c1", pc_en, 0);
    chk("raw_bubble_c1", id_ex_bubble, 1);
    chk("raw_busy", busy, 1);
    tick(); #1;
    chk("raw_stall_c2", stall, 1);
    tick();
    wb_valid = 1; wb_rd = 3'd3; #1;
    chk("raw_stall_c3_wb", stall, 1);
    tick();
    wb_valid = 0; #1;
    chk("raw_release", stall, 0);
    chk("raw_if_id_en", if_id_en, 1);
    chk("raw_busy_clear", busy, 0);
    clr();

    // Register zero never reserves or stalls
    iss(3'd0);
    probe1(3'd0);
    chk("r0_stall", stall, 0);
    chk("r0_busy", busy, 0);
    ret(3'd0);
    #1;
    chk("r0_wb_no_err", err, 0);
    clr();

    // r5: issue and retire together keeps count at 1
    iss(3'd5);
    issue_valid = 1; issue_wb_en = 1; issue_rd = 3'd5;
    wb_valid = 1; wb_rd = 3'd5;
    tick();
    clr();
    probe1(3'd5);
    chk("r5_net0_stall", stall, 1);
    rs1_use = 0;
    ret(3'd5);
    probe1(3'd5);
    chk("r5_cnt1_released", stall, 0);
    chk("r5_busy0", busy, 0);
    chk("r5_err0", err, 0);
    clr();

    // r5: kill and retire together at count 2 gives 0
    iss(3'd5);
    iss(3'd5);
    wb_valid = 1; wb_rd = 3'd5; kill_valid = 1; kill_rd = 3'd5;
    tick();
    clr();
    probe1(3'd5);
    chk("r5_m2_stall", stall, 0);
    chk("r5_m2_busy", busy, 0);
    chk("r5_m2_err", err, 0);
    clr();

    // Kill alone releases a reservation
    iss(3'd7);
    kill_valid = 1; kill_rd = 3'd7;
    tick();
    clr(); #1;
    chk("kill_release_busy", busy, 0);

    // Issue to r4 blocked while rs2=r2 stalls
    iss(3'd2);
    rs2 = 3'd2; rs2_use = 1;
    issue_valid = 1; issue_wb_en = 1; issue_rd = 3'd4; #1;
    chk("blk_stall_rs2", stall, 1);
    tick();
    clr();
    probe1(3'd4);
    chk("blk_r4_unchanged", stall, 0);
    rs1_use = 0;
    ret(3'd2);
    #1;
    chk("blk_busy_clear", busy, 0);
    iss(3'd4);
    probe1(3'd4);
    chk("blk_r4_after_unstall", stall, 1);
    rs1_use = 0;
    ret(3'd4);
    clr();

    // Underflow on r6
    ret(3'd6);
    probe1(3'd6);
    chk("uf_err", err, 1);
    chk("uf_cnt0_stall", stall, 0);
    chk("uf_cnt0_busy", busy, 0);
    clr();

    // Reset clears err; then overflow on r6
    rst_n = 0; #1;
    chk("rst2_err", err, 0);
    rst_n = 1;
    tick();
    iss(3'd6); iss(3'd6); iss(3'd6);
    #1;
    chk("of_3_no_err", err, 0);
    iss(3'd6);
    #1;
    chk("of_4_err", err, 1);
    ret(3'd6); ret(3'd6);
    #1;
    chk("of_busy_after2", busy, 1);
    ret(3'd6);
    #1;
    chk("of_held3_busy0", busy, 0);
    chk("of_err_sticky", err, 1);

    // Mid-operation asynchronous reset discards reservations
    iss(3'd1);
    probe1(3'd1);
    chk("mid_stall_pre", stall, 1);
    #2 rst_n = 0; #1;
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err, 0);
    rst_n = 1;
    clr();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
